// File: rtl/button_event_conditioner_if.sv
// Raw button inputs and the conditioned level/press/release event outputs
// exchanged between the button producer and the button_event_conditioner.
interface button_event_conditioner_if #(
  parameter int WIDTH = 24
);
  logic [WIDTH-1:0] buttons_raw;
  logic [WIDTH-1:0] buttons_level;
  logic [WIDTH-1:0] buttons_press;
  logic [WIDTH-1:0] buttons_release;
  logic             any_press;
  logic             sample_tick;

  modport master (
    output buttons_raw,
    input  buttons_level,
    input  buttons_press,
    input  buttons_release,
    input  any_press,
    input  sample_tick
  );

  modport slave (
    input  buttons_raw,
    output buttons_level,
    output buttons_press,
    output buttons_release,
    output any_press,
    output sample_tick
  );
endinterface

// File: rtl/button_event_conditioner.sv
// Synchronises and debounces WIDTH raw button lines on a shared sample tick and
// emits a clean level vector plus single-cycle press/release pulses.
module button_event_conditioner #(
  parameter int WIDTH          = 24,
  parameter int CLK_DIV        = 50000,
  parameter int STABLE_SAMPLES = 4
) (
  input logic                       clk,
  input logic                       rst_n,
  button_event_conditioner_if.slave bus
);

  localparam int TW = $clog2(CLK_DIV);
  localparam int CW = $clog2(STABLE_SAMPLES + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_SAMPLES - 1);

  typedef enum logic {
    STABLE   = 1'b0,
    CHANGING = 1'b1
  } db_state_e;

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic             tick_q, tick_d;

  db_state_e        state_q [WIDTH];
  db_state_e        state_d [WIDTH];
  logic [CW-1:0]    cnt_q   [WIDTH];
  logic [CW-1:0]    cnt_d   [WIDTH];

  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] press_q, press_d;
  logic [WIDTH-1:0] release_q, release_d;
  logic             any_press_q, any_press_d;

  // The tick flop is registered off the next count so it is high exactly while
  // the counter sits at CLK_DIV-1.
  always_comb begin
    sync1_d    = bus.buttons_raw;
    sync2_d    = sync1_q;
    tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TW'(1);
    tick_d     = (tick_cnt_d == TICK_LAST);
  end

  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (tick_q) begin
        if (sync2_q[i] == level_q[i]) begin
          // An agreeing sample cancels any run in progress (bounce rejection).
          cnt_d[i]   = '0;
          state_d[i] = STABLE;
        end else if (STABLE_SAMPLES == 1 ||
                     (state_q[i] == CHANGING && cnt_q[i] == CNT_LAST)) begin
          level_d[i]   = ~level_q[i];
          press_d[i]   = ~level_q[i];
          release_d[i] = level_q[i];
          cnt_d[i]     = '0;
          state_d[i]   = STABLE;
        end else begin
          cnt_d[i]   = cnt_q[i] + CW'(1);
          state_d[i] = CHANGING;
        end
      end
    end
    any_press_d = |press_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      tick_cnt_q  <= '0;
      tick_q      <= 1'b0;
      level_q     <= '0;
      press_q     <= '0;
      release_q   <= '0;
      any_press_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      tick_cnt_q  <= tick_cnt_d;
      tick_q      <= tick_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      any_press_q <= any_press_d;
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign bus.buttons_level   = level_q;
  assign bus.buttons_press   = press_q;
  assign bus.buttons_release = release_q;
  assign bus.any_press       = any_press_q;
  assign bus.sample_tick     = tick_q;

endmodule

// File: tb/tb_button_event_conditioner.sv
// Randomised and directed bench for button_event_conditioner with a scoreboard
// fed by a sample-history reference model.
module tb_button_event_conditioner;

  localparam int W  = 24;
  localparam int CD = 4;
  localparam int SS = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] raw = '0;

  button_event_conditioner_if #(.WIDTH(W)) bus ();
  assign bus.buttons_raw = raw;

  button_event_conditioner #(
    .WIDTH(W),
    .CLK_DIV(CD),
    .STABLE_SAMPLES(SS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned  edge_no;
    logic [W-1:0] press;
    logic [W-1:0] rel;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  int           n_checks = 0;
  int           n_pass = 0;
  int unsigned  edge_cnt = 0;
  int           press_cnt[W];
  int           rel_cnt[W];

  // Reference model: a new level is accepted once the last SS tick samples of
  // the twice-delayed raw line all disagree with the current level.
  logic [W-1:0] m_s1, m_s2, m_level, m_pr, m_rl;
  logic [W-1:0] m_samples[$];
  int unsigned  m_cyc;
  bit           m_alldiff;

  function automatic void checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  function automatic void checkRange(string name, int act, int lo, int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endfunction

  task automatic applyStimulus(input logic [W-1:0] v);
    @(negedge clk);
    #1 raw = v;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitPress(input int b, input int max, output int lat,
                           output logic [W-1:0] pv, output logic ap);
    lat = -1;
    pv  = '0;
    ap  = 1'b0;
    for (int n = 1; n <= max; n++) begin
      @(negedge clk);
      if (bus.buttons_press[b]) begin
        lat = n;
        pv  = bus.buttons_press;
        ap  = bus.any_press;
        break;
      end
    end
  endtask

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  for (genvar g = 0; g < W; g++) begin : g_cnt_init
    initial begin
      press_cnt[g] = 0;
      rel_cnt[g]   = 0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1    = '0;
      m_s2    = '0;
      m_level = '0;
      m_cyc   = 0;
      m_samples.delete();
      exp_q.delete();
    end else begin
      if (m_cyc % CD == CD - 1) begin
        m_samples.push_back(m_s2);
        m_pr = '0;
        m_rl = '0;
        if (m_samples.size() >= SS) begin
          for (int i = 0; i < W; i++) begin
            m_alldiff = 1'b1;
            for (int k = 0; k < SS; k++)
              if (m_samples[m_samples.size() - 1 - k][i] == m_level[i]) m_alldiff = 1'b0;
            if (m_alldiff) begin
              if (m_level[i]) m_rl[i] = 1'b1;
              else            m_pr[i] = 1'b1;
              m_level[i] = ~m_level[i];
            end
          end
        end
        if ((m_pr | m_rl) != '0)
          exp_q.push_back('{edge_no: edge_cnt + 1, press: m_pr, rel: m_rl});
      end
      m_s2  = m_s1;
      m_s1  = raw;
      m_cyc = m_cyc + 1;
    end
  end

  // Monitor: per-cycle level/tick checks, and scoreboard pops on every event.
  always @(negedge clk) begin
    checkOutput("level", bus.buttons_level, m_level);
    checkOutput("sample_tick", bus.sample_tick, (m_cyc % CD) == CD - 1);
    checkOutput("press_release_overlap", bus.buttons_press & bus.buttons_release, 0);
    if (bus.buttons_press != '0 || bus.buttons_release != '0) begin
      for (int i = 0; i < W; i++) begin
        if (bus.buttons_press[i])   press_cnt[i]++;
        if (bus.buttons_release[i]) rel_cnt[i]++;
      end
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_event", {bus.buttons_press, bus.buttons_release}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("event_edge", edge_cnt, mon_e.edge_no);
        checkOutput("event_press", bus.buttons_press, mon_e.press);
        checkOutput("event_release", bus.buttons_release, mon_e.rel);
        checkOutput("event_any_press", bus.any_press, |mon_e.press);
      end
    end else begin
      checkOutput("any_press_idle", bus.any_press, 0);
      if (exp_q.size() > 0 && exp_q[0].edge_no <= edge_cnt) begin
        checkOutput("missing_event", 0, {exp_q[0].press, exp_q[0].rel});
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int           lat;
    int           n;
    bit           found;
    logic [W-1:0] pv;
    logic         ap;
    logic [W-1:0] mask;

    repeat (3) @(negedge clk);
    checkOutput("reset_level", bus.buttons_level, 0);
    checkOutput("reset_press", bus.buttons_press, 0);
    checkOutput("reset_release", bus.buttons_release, 0);
    checkOutput("reset_any_press", bus.any_press, 0);
    checkOutput("reset_tick", bus.sample_tick, 0);
    #1 rst_n = 1'b1;

    // Tick is visible after CD-1 edges and consumed on the CD-th edge.
    n = 0;
    found = 0;
    while (!found && n < 10) begin
      @(negedge clk);
      n++;
      if (bus.sample_tick) found = 1;
    end
    checkOutput("first_tick_edges", n, CD - 1);
    waitCycles(40);

    applyStimulus(24'h000001);
    waitPress(0, 30, lat, pv, ap);
    checkRange("press0_latency", lat, 11, 15);
    checkOutput("press0_any_press", ap, 1);
    @(negedge clk);
    checkOutput("press0_single_pulse", bus.buttons_press[0], 0);
    checkOutput("press0_any_after", bus.any_press, 0);
    checkOutput("press0_level", bus.buttons_level[0], 1);

    waitCycles(10);
    applyStimulus(raw | 24'h000020);
    waitCycles(3);
    applyStimulus(raw & ~24'h000020);
    waitCycles(3);
    applyStimulus(raw | 24'h000020);
    waitCycles(25);
    checkOutput("press5_count", press_cnt[5], 1);
    checkOutput("level5_high", bus.buttons_level[5], 1);
    applyStimulus(raw & ~24'h000020);
    waitCycles(25);
    checkOutput("release5_count", rel_cnt[5], 1);
    checkOutput("level5_low", bus.buttons_level[5], 0);

    applyStimulus(24'h000000);
    waitCycles(25);
    applyStimulus(24'h000003);
    waitPress(0, 30, lat, pv, ap);
    checkOutput("dual_press_vec", pv, 24'h000003);
    checkOutput("dual_any_press", ap, 1);
    @(negedge clk);
    checkOutput("dual_press_single", bus.buttons_press, 0);

    applyStimulus(24'h000000);
    waitCycles(25);
    applyStimulus(24'h000002);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (m_samples.size() >= 2 && m_samples[m_samples.size() - 1][1] &&
          m_samples[m_samples.size() - 2][1] && !m_level[1])
        found = 1;
    end
    checkOutput("midcount_reached", found, 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midreset_level", bus.buttons_level, 0);
    checkOutput("midreset_press", bus.buttons_press, 0);
    checkOutput("midreset_any_press", bus.any_press, 0);
    checkOutput("midreset_tick", bus.sample_tick, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    waitPress(1, 30, lat, pv, ap);
    checkOutput("press1_after_reset_latency", lat, 12);

    waitCycles(5);
    found = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge clk);
      if (m_cyc % CD == 0) found = 1;
    end
    #1 raw = raw | 24'h000080;
    applyStimulus(raw & ~24'h000080);
    waitCycles(20);
    checkOutput("glitch7_press_count", press_cnt[7], 0);
    checkOutput("glitch7_level", bus.buttons_level[7], 0);

    for (int c = 0; c < 1500; c++) begin
      mask = '0;
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 47) == 0) mask[i] = 1'b1;
      applyStimulus(raw ^ mask);
    end
    applyStimulus(24'h000000);
    waitCycles(40);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    checkOutput("final_level", bus.buttons_level, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
